// File: rtl/r4_multicycle_ctrl.sv
// r4_multicycle_ctrl: multi-cycle control FSM for the R4 RV32I core.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) over the shared datapath,
// drives datapath selects/write enables, owns the memory request handshake and
// counts retired instructions.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : unknown opcodes (and memory timeouts when MEM_TIMEOUT > 0) enter
//               TRAP, which is sticky until reset.
//   undefined : unknown opcodes retire as 2-cycle NOPs, trap is tied low.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   instr                IR contents (opcode/rd decoded here)
//   br_taken             branch comparator result, used in EXEC
//   mem_ready            memory completes the current request this cycle
//   mem_req/mem_we       memory request / store qualifier
//   addr_sel             memory address: 0 = PC, 1 = ALU result
//   ir_we, pc_we, pc_sel IR latch, PC update and PC source
//   reg_we, wb_sel       register write enable and write-back source
//   alu_a_sel/alu_b_sel  ALU operand selects
//   alu_ctl              0 = add, 1 = funct decode, 2 = branch compare
//   state                current state encoding
//   retire, instret      retire pulse and retired-instruction count
//   trap                 sticky illegal/timeout flag
module r4_multicycle_ctrl #(
  parameter logic [31:0] RESET_INSTRET = 32'd0,
  parameter int unsigned MEM_TIMEOUT   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  alu_ctl,
  output logic [2:0]  state,
  output logic        retire,
  output logic [31:0] instret,
  output logic        trap
);

  localparam int unsigned OPC_W = 7;
  localparam int unsigned CNT_W = 32;

  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_LOAD  = 2'd1;
  localparam logic [1:0] WB_LINK  = 2'd2;

  localparam logic [1:0] A_RS1    = 2'd0;
  localparam logic [1:0] A_PC     = 2'd1;
  localparam logic [1:0] A_ZERO   = 2'd2;

  localparam logic [1:0] CTL_ADD  = 2'd0;
  localparam logic [1:0] CTL_FUNC = 2'd1;
  localparam logic [1:0] CTL_BR   = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       instret_q;
  logic [OPC_W-1:0]       opcode;
  logic                   rd_nz;
  logic                   known;
  logic [1:0]             op_a_sel;
  logic                   op_b_sel;
  logic [1:0]             op_ctl;
  logic                   unused_instr;

  assign opcode       = instr[6:0];
  assign rd_nz        = (instr[11:7] != 5'd0);
  assign unused_instr = ^instr[31:12];
  assign state        = state_q;
  assign instret      = instret_q;

  // Opcode recognition and the ALU operand setup held through EXEC/MEM/WB.
  always_comb begin
    known    = 1'b1;
    op_a_sel = A_RS1;
    op_b_sel = 1'b0;
    op_ctl   = CTL_ADD;
    case (opcode)
      OPC_LUI:    begin op_a_sel = A_ZERO; op_b_sel = 1'b1; end
      OPC_AUIPC:  begin op_a_sel = A_PC;   op_b_sel = 1'b1; end
      OPC_JAL:    ;
      OPC_JALR:   op_b_sel = 1'b1;
      OPC_OPIMM:  begin op_b_sel = 1'b1; op_ctl = CTL_FUNC; end
      OPC_OP:     op_ctl = CTL_FUNC;
      OPC_LOAD,
      OPC_STORE:  op_b_sel = 1'b1;
      OPC_BRANCH: op_ctl = CTL_BR;
      default:    known = 1'b0;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  localparam int unsigned TMO_W = 16;
  localparam logic [TMO_W-1:0] TMO_LIM =
    (MEM_TIMEOUT > 65535) ? 16'hFFFF : TMO_W'(MEM_TIMEOUT);

  logic [TMO_W-1:0] wait_q;
  logic             req_state;
  logic             timeout_hit;
  logic             trap_q;

  assign req_state   = (state_q == S_FETCH) || (state_q == S_MEM);
  assign timeout_hit = (MEM_TIMEOUT != 0) && req_state && !mem_ready && (wait_q >= TMO_LIM);
  assign trap        = trap_q;

  // Wait-cycle counter for the outstanding request; saturates rather than wraps.
  always_ff @(posedge clk) begin
    if (reset || !req_state || mem_ready) begin
      wait_q <= '0;
    end else if (wait_q != {TMO_W{1'b1}}) begin
      wait_q <= wait_q + TMO_W'(1);
    end
  end

  // Sticky trap flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      trap_q <= 1'b0;
    end else if (state_d == S_TRAP) begin
      trap_q <= 1'b1;
    end
  end
`else
  assign trap = 1'b0;
  // Timeout hardware exists only with the trap feature.
  if (MEM_TIMEOUT != 0) begin : g_timeout_ignored
  end
`endif

  // Next-state and control decode; every control is forced low during reset.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    alu_a_sel = A_RS1;
    alu_b_sel = 1'b0;
    alu_ctl   = CTL_ADD;
    retire    = 1'b0;

    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            state_d = S_DECODE;
          end
`ifdef ILLEGAL_TRAP_EN
          else if (timeout_hit) begin
            state_d = S_TRAP;
          end
`endif
        end

        S_DECODE: begin
          if (known) begin
            state_d = S_EXEC;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            pc_we   = 1'b1;
            pc_sel  = PC_PLUS4;
            retire  = 1'b1;
            state_d = S_FETCH;
`endif
          end
        end

        S_EXEC: begin
          alu_a_sel = op_a_sel;
          alu_b_sel = op_b_sel;
          alu_ctl   = op_ctl;
          if (opcode == OPC_BRANCH) begin
            pc_we   = 1'b1;
            pc_sel  = br_taken ? PC_IMM : PC_PLUS4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end

        S_MEM: begin
          alu_a_sel = op_a_sel;
          alu_b_sel = op_b_sel;
          alu_ctl   = op_ctl;
          mem_req   = 1'b1;
          addr_sel  = 1'b1;
          mem_we    = (opcode == OPC_STORE);
          if (mem_ready) begin
            if (opcode == OPC_STORE) begin
              pc_we   = 1'b1;
              pc_sel  = PC_PLUS4;
              retire  = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end
`ifdef ILLEGAL_TRAP_EN
          else if (timeout_hit) begin
            state_d = S_TRAP;
          end
`endif
        end

        S_WB: begin
          // ALU stays set up so AUIPC/LUI/OP results and the JALR target are valid.
          alu_a_sel = op_a_sel;
          alu_b_sel = op_b_sel;
          alu_ctl   = op_ctl;
          reg_we    = rd_nz;
          pc_we     = 1'b1;
          retire    = 1'b1;
          state_d   = S_FETCH;
          if (opcode == OPC_LOAD) begin
            wb_sel = WB_LOAD;
          end else if (opcode == OPC_JAL || opcode == OPC_JALR) begin
            wb_sel = WB_LINK;
          end
          if (opcode == OPC_JAL) begin
            pc_sel = PC_IMM;
          end else if (opcode == OPC_JALR) begin
            pc_sel = PC_ALU;
          end
        end

        S_TRAP: state_d = S_TRAP;

        default: state_d = S_FETCH;
      endcase
    end
  end

  // State register and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= RESET_INSTRET;
    end else begin
      state_q <= state_d;
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_r4_multicycle_ctrl.sv
// Self-checking bench for r4_multicycle_ctrl (default build, trap feature off).
// Directed table vectors, hand-written multi-cycle sequences, and randomized
// instructions/memory wait patterns checked against an instruction-level model.
module tb_r4_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        br_taken;
  logic        mem_ready;

  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, alu_b_sel, retire, trap;
  logic [1:0]  pc_sel, wb_sel, alu_a_sel, alu_ctl;
  logic [2:0]  state;
  logic [31:0] instret;

  logic        w_mem_req, w_mem_we, w_addr_sel, w_ir_we, w_pc_we, w_reg_we, w_alu_b_sel, w_retire, w_trap;
  logic [1:0]  w_pc_sel, w_wb_sel, w_alu_a_sel, w_alu_ctl;
  logic [2:0]  w_state;
  logic [31:0] w_instret;

  r4_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .br_taken(br_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .alu_ctl(alu_ctl), .state(state), .retire(retire),
    .instret(instret), .trap(trap)
  );

  // Second instance preloaded near wrap; shares all inputs with dut.
  r4_multicycle_ctrl #(.RESET_INSTRET(32'hFFFF_FFFF)) dut_wrap (
    .clk(clk), .reset(reset), .instr(instr), .br_taken(br_taken), .mem_ready(mem_ready),
    .mem_req(w_mem_req), .mem_we(w_mem_we), .addr_sel(w_addr_sel), .ir_we(w_ir_we), .pc_we(w_pc_we),
    .pc_sel(w_pc_sel), .reg_we(w_reg_we), .wb_sel(w_wb_sel), .alu_a_sel(w_alu_a_sel),
    .alu_b_sel(w_alu_b_sel), .alu_ctl(w_alu_ctl), .state(w_state), .retire(w_retire),
    .instret(w_instret), .trap(w_trap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_instret = 32'd0;
  logic [2:0]  st_trace [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Instruction class: 0 alu/upper, 1 jump, 2 branch, 3 load, 4 store, 5 unknown.
  function automatic int cls(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    case (op)
      7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011: return 0;
      7'b1101111, 7'b1100111:                         return 1;
      7'b1100011:                                     return 2;
      7'b0000011:                                     return 3;
      7'b0100011:                                     return 4;
      default:                                        return 5;
    endcase
  endfunction

  function automatic int base_lat(input int c);
    case (c)
      2: return 3;
      3: return 5;
      5: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [6:0] pick_op(input int k);
    case (k)
      0: return 7'b0110111;
      1: return 7'b0010111;
      2: return 7'b1101111;
      3: return 7'b1100111;
      4: return 7'b1100011;
      5: return 7'b0000011;
      6: return 7'b0100011;
      7: return 7'b0010011;
      default: return 7'b0110011;
    endcase
  endfunction

  // Runs one instruction from FETCH until its retire pulse; returns what was observed.
  task automatic run_instr(input logic [31:0] ins, input logic br, input bit use_pat,
                           input logic [31:0] pat, input int prob,
                           output int cyc, output int waits, output bit rw, output bit mw,
                           output logic [1:0] psel, output logic [1:0] wsel, output logic pwe);
    bit done, prev_wait;
    logic prev_we, prev_as;
    instr = ins;
    br_taken = br;
    cyc = 0; waits = 0; rw = 0; mw = 0; psel = 2'd0; wsel = 2'd0; pwe = 1'b0;
    done = 0; prev_wait = 0; prev_we = 1'b0; prev_as = 1'b0;
    while (!done && cyc < 200) begin
      mem_ready = use_pat ? pat[cyc % 32] : (int'($urandom_range(99)) < prob);
      @(negedge clk);
      if (cyc < 16) st_trace[cyc] = state;
      if (prev_wait) chk("req_stable", {29'd0, mem_req, mem_we, addr_sel}, {29'd0, 1'b1, prev_we, prev_as});
      prev_wait = mem_req && !mem_ready;
      prev_we = mem_we;
      prev_as = addr_sel;
      if (prev_wait) waits++;
      if (reg_we) rw = 1;
      if (mem_req && mem_we) mw = 1;
      if (retire) begin
        psel = pc_sel; wsel = wb_sel; pwe = pc_we; done = 1;
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    if (!done) chk("retire_timeout", 32'd0, 32'd1);
    exp_instret = exp_instret + 32'd1;
    chk("instret", instret, exp_instret);
    chk("instret_wrap", w_instret, exp_instret + 32'hFFFF_FFFF);
    chk("back_to_fetch", {29'd0, state}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] ins;
    logic        br;
    int          cyc;
    logic [1:0]  psel;
    logic [1:0]  wsel;
    bit          rw;
    bit          mw;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int cyc, waits;
    bit rw, mw;
    logic [1:0] psel, wsel;
    logic pwe;

    tbl[0]  = '{32'h0050_0093, 1'b0, 4, 2'd0, 2'd0, 1'b1, 1'b0}; // addi x1,x0,5
    tbl[1]  = '{32'h0000_A103, 1'b0, 5, 2'd0, 2'd1, 1'b1, 1'b0}; // lw x2,0(x1)
    tbl[2]  = '{32'h0020_A223, 1'b0, 4, 2'd0, 2'd0, 1'b0, 1'b1}; // sw x2,4(x1)
    tbl[3]  = '{32'h0000_0463, 1'b1, 3, 2'd1, 2'd0, 1'b0, 1'b0}; // beq taken
    tbl[4]  = '{32'h0000_0463, 1'b0, 3, 2'd0, 2'd0, 1'b0, 1'b0}; // beq not taken
    tbl[5]  = '{32'h0080_00EF, 1'b0, 4, 2'd1, 2'd2, 1'b1, 1'b0}; // jal x1,8
    tbl[6]  = '{32'h0000_8067, 1'b0, 4, 2'd2, 2'd2, 1'b0, 1'b0}; // jalr x0,0(x1)
    tbl[7]  = '{32'h1234_52B7, 1'b0, 4, 2'd0, 2'd0, 1'b1, 1'b0}; // lui x5
    tbl[8]  = '{32'h0000_1017, 1'b0, 4, 2'd0, 2'd0, 1'b0, 1'b0}; // auipc x0
    tbl[9]  = '{32'h0020_81B3, 1'b0, 4, 2'd0, 2'd0, 1'b1, 1'b0}; // add x3,x1,x2
    tbl[10] = '{32'h0000_0000, 1'b0, 2, 2'd0, 2'd0, 1'b0, 1'b0}; // unknown -> NOP

    // Reset state, controls low while reset is high.
    reset = 1'b1; instr = 32'd0; br_taken = 1'b0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_pc_we", {31'd0, pc_we}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_instret_pre", w_instret, 32'hFFFF_FFFF);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // addi with zero-wait memory: states 0,1,2,4; second instance wraps to 0.
    run_instr(32'h0050_0093, 1'b0, 1'b1, 32'hFFFF_FFFF, 0, cyc, waits, rw, mw, psel, wsel, pwe);
    chk("addi_cycles", cyc, 4);
    chk("addi_trace", {20'd0, st_trace[0], st_trace[1], st_trace[2], st_trace[3]},
        {20'd0, 3'd0, 3'd1, 3'd2, 3'd4});
    chk("addi_wb", {25'd0, rw, wsel, pwe, psel}, {25'd0, 1'b1, 2'd0, 1'b1, 2'd0});
    chk("wrap_zero", w_instret, 32'd0);

    // lw with two MEM wait cycles (mem_ready high in DECODE/EXEC is ignored).
    run_instr(32'h0000_A103, 1'b0, 1'b1, 32'hFFFF_FFE7, 0, cyc, waits, rw, mw, psel, wsel, pwe);
    chk("lw_cycles", cyc, 7);
    chk("lw_waits", waits, 2);
    chk("lw_mem_trace", {23'd0, st_trace[3], st_trace[4], st_trace[5]}, {23'd0, 3'd3, 3'd3, 3'd3});
    chk("lw_wb", {29'd0, rw, wsel}, {29'd0, 1'b1, 2'd1});
    chk("lw_wb_state", {29'd0, st_trace[6]}, 32'd4);

    // Directed table, zero-wait memory.
    for (int i = 0; i < 11; i++) begin
      run_instr(tbl[i].ins, tbl[i].br, 1'b1, 32'hFFFF_FFFF, 0, cyc, waits, rw, mw, psel, wsel, pwe);
      chk($sformatf("tbl%0d_cycles", i), cyc, tbl[i].cyc);
      chk($sformatf("tbl%0d_pc", i), {29'd0, pwe, psel}, {29'd0, 1'b1, tbl[i].psel});
      chk($sformatf("tbl%0d_wbsel", i), {30'd0, wsel}, {30'd0, tbl[i].wsel});
      chk($sformatf("tbl%0d_we", i), {30'd0, rw, mw}, {30'd0, tbl[i].rw, tbl[i].mw});
    end

    // Randomized instructions and memory stalls against the instruction-level model.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] ins;
      logic br;
      int k, c;
      bit exp_rw;
      logic [1:0] exp_ps, exp_ws;
      ins = $urandom;
      k = int'($urandom_range(9));
      if (k < 9) begin
        ins[6:0] = pick_op(k);
      end else begin
        while (cls(ins) != 5) ins[6:0] = 7'($urandom);
      end
      br = 1'($urandom);
      c = cls(ins);
      exp_rw = (c == 0 || c == 1 || c == 3) && (ins[11:7] != 5'd0);
      exp_ws = (c == 3) ? 2'd1 : (c == 1) ? 2'd2 : 2'd0;
      if (c == 2)                   exp_ps = br ? 2'd1 : 2'd0;
      else if (ins[6:0] == 7'h6F)   exp_ps = 2'd1;
      else if (ins[6:0] == 7'h67)   exp_ps = 2'd2;
      else                          exp_ps = 2'd0;
      run_instr(ins, br, 1'b0, 32'd0, 60, cyc, waits, rw, mw, psel, wsel, pwe);
      chk($sformatf("rnd%0d_latency", n), cyc, base_lat(c) + waits);
      chk($sformatf("rnd%0d_regwe", n), {31'd0, rw}, {31'd0, exp_rw});
      chk($sformatf("rnd%0d_memwe", n), {31'd0, mw}, {31'd0, (c == 4)});
      chk($sformatf("rnd%0d_pc", n), {29'd0, pwe, psel}, {29'd0, 1'b1, exp_ps});
      chk($sformatf("rnd%0d_wbsel", n), {30'd0, wsel}, {30'd0, exp_ws});
    end
    chk("trap_tied", {31'd0, trap}, 32'd0);

    // Reset during a FETCH wait drops mem_req immediately and reloads instret.
    mem_ready = 1'b0;
    @(negedge clk);
    chk("fetch_wait_req", {28'd0, state, mem_req}, {28'd0, 3'd0, 1'b1});
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_req", {30'd0, mem_req, retire}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_mid_state", {29'd0, state}, 32'd0);
    chk("rst_mid_instret", instret, 32'd0);
    chk("rst_mid_instret_pre", w_instret, 32'hFFFF_FFFF);
    reset = 1'b0;
    exp_instret = 32'd0;
    run_instr(32'h0050_0093, 1'b0, 1'b1, 32'hFFFF_FFFF, 0, cyc, waits, rw, mw, psel, wsel, pwe);
    chk("post_rst_cycles", cyc, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/r4_multicycle_ctrl.md
Name: r4_multicycle_ctrl

Overview:
Multi-cycle control FSM for the R4 RV32I core. Sequences one instruction at a time through fetch, decode, execute, memory and writeback over the shared register file, immediate generator, ALU and single memory port. Drives datapath mux selects and write enables, and owns the memory request handshake. Keeps a retired-instruction counter.

Parameters:
RESET_INSTRET, 0, initial value of instret after reset
MEM_TIMEOUT, 0, max wait cycles per memory request; 0 = no limit (only used with ILLEGAL_TRAP_EN)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
instr  in  32  instruction register contents from datapath
br_taken  in  1  branch comparator result, valid in EXEC
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request
mem_we  out  1  1 = store, 0 = read
addr_sel  out  1  memory address: 0 = PC, 1 = ALU result
ir_we  out  1  latch fetched word into IR
pc_we  out  1  PC update
pc_sel  out  2  0 = PC+4, 1 = PC+imm, 2 = ALU result & ~1
reg_we  out  1  register file write
wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4
alu_a_sel  out  2  0 = rs1, 1 = PC, 2 = zero
alu_b_sel  out  1  0 = rs2, 1 = imm
alu_ctl  out  2  0 = add, 1 = funct3/funct7 decode, 2 = branch compare
state  out  3  current state encoding
retire  out  1  one-cycle pulse when an instruction completes
instret  out  32  retired-instruction count
trap  out  1  sticky illegal/timeout flag

Behaviour:
- Reset (sync, active-high): state <= FETCH(0), instret <= RESET_INSTRET, trap <= 0. All control outputs are 0 while reset is high.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- All controls are combinational from state and instr[6:0]/funct3. Only state, instret and trap are registered.
- FETCH: mem_req=1, addr_sel=0, mem_we=0. Hold until mem_ready. On mem_ready: ir_we=1, next state DECODE.
- DECODE: 1 cycle. Recognised opcodes go to EXEC: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011. Other opcodes: see Optional Feature.
- EXEC operand selects:
  - LUI: a=zero, b=imm, add.
  - AUIPC: a=PC, b=imm, add.
  - JAL: no ALU use.
  - JALR: a=rs1, b=imm, add.
  - OP-IMM: a=rs1, b=imm, ctl=1.
  - OP: a=rs1, b=rs2, ctl=1.
  - LOAD/STORE: a=rs1, b=imm, add.
  - BRANCH: a=rs1, b=rs2, ctl=2.
- EXEC next state:
  - BRANCH: pc_we=1, pc_sel = br_taken ? 1 : 0, retire=1, go to FETCH.
  - LOAD/STORE: go to MEM.
  - All others: go to WB.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for STORE. ALU selects stay as in EXEC. Hold until mem_ready.
  - LOAD: go to WB.
  - STORE: pc_we=1, pc_sel=0, retire=1, go to FETCH.
- WB: reg_we=1 only when instr[11:7] != 0, then go to FETCH.
  - wb_sel: 1 for LOAD; 2 for JAL/JALR; 0 otherwise.
  - pc_we=1; pc_sel: 1 for JAL, 2 for JALR, 0 otherwise.
  - retire=1.
- mem_req, mem_we and addr_sel stay stable from assertion until the mem_ready cycle. mem_ready outside FETCH/MEM is ignored.
- Latency with zero-wait memory (mem_ready high in the first request cycle):
  - BRANCH: 3 cycles.
  - STORE and ALU/jump/upper-immediate: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds one.
- instret increments by 1 on each retire and wraps from 0xFFFFFFFF to 0.
- Reset mid-request drops mem_req in the same cycle reset is sampled high. No retire occurs and instret is reloaded.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined:
  - An unrecognised opcode in DECODE moves to TRAP and sets trap=1.
  - With MEM_TIMEOUT>0, a memory request waiting more than MEM_TIMEOUT cycles also enters TRAP. Timeout counter is 16 bits, cleared on each new request.
  - TRAP asserts no controls and is left only by reset.
- Undefined:
  - An unrecognised opcode is a NOP: DECODE asserts pc_we=1, pc_sel=0, retire=1 and goes to FETCH.
  - trap is tied 0; no timeout logic is present.

Test Plan:
1. Reset, then hold mem_ready=1 with instr=0x00500093 (addi x1,x0,5) -> states 0,1,2,4. In WB: reg_we=1, wb_sel=0, pc_we=1, pc_sel=0, retire=1. instret=1.
2. instr=0x0000A103 (lw x2,0(x1)) with mem_ready low for 2 MEM cycles -> 7-cycle sequence. mem_req/addr_sel=1 stable through the wait. WB: wb_sel=1, reg_we=1.
3. instr=0x0020A223 (sw x2,4(x1)) -> MEM has mem_we=1. Retire happens in MEM, no WB state, reg_we never asserted.
4. instr=0x00000463 (beq x0,x0,8): br_taken=1 -> EXEC pc_sel=1, pc_we=1. Repeat with br_taken=0 -> pc_sel=0. Each takes 3 cycles.
5. instr=0x00000000 -> with ILLEGAL_TRAP_EN: state=5, trap=1, no further mem_req until reset. Without it: 2-cycle NOP with retire=1.
6. Preload via RESET_INSTRET=0xFFFFFFFF and retire once -> instret=0. Assert reset during a FETCH wait -> next cycle mem_req=0, state=0.
